// File: rtl/tx_scheduler.sv
// rtl/tx_scheduler.sv - transmit sequencer: IDLE/LOAD/START/TRANSMIT/GUARD with pending request, abort and optional TX_PERIODIC_EN auto-trigger
module tx_scheduler #(
  parameter int SEQ_BITS       = 1024,
  parameter int SYMBOL_SAMPLES = 40,
  parameter int GUARD_CYCLES   = 4096,
  parameter int PERIOD_CYCLES  = 65536
) (
  input  logic                        ctx_clk,
  input  logic                        rtx_rst,
  input  logic                        ienable,
  input  logic                        itx_request,
  input  logic                        iabort,
  input  logic [SEQ_BITS-1:0]         isequence,
  output logic [SEQ_BITS-1:0]         obinary_sequence,
  output logic                        ostart_interrupt,
  output logic                        otx_enable,
  output logic                        obusy,
  output logic                        odone,
  output logic [$clog2(SEQ_BITS)-1:0] obit_index,
  output logic [15:0]                 otx_count
);

  localparam int IDX_W   = $clog2(SEQ_BITS);
  localparam int SAMP_W  = (SYMBOL_SAMPLES > 1) ? $clog2(SYMBOL_SAMPLES) : 1;
  localparam int GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [IDX_W-1:0]   BIT_LAST   = IDX_W'(SEQ_BITS - 1);
  localparam logic [SAMP_W-1:0]  SAMP_LAST  = SAMP_W'(SYMBOL_SAMPLES - 1);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_TRANSMIT, S_GUARD} state_t;

  state_t               state_q, state_d;
  logic [SEQ_BITS-1:0]  seq_q, seq_d;
  logic                 tx_en_q, tx_en_d;
  logic                 done_q, done_d;
  logic [IDX_W-1:0]     bit_q, bit_d;
  logic [SAMP_W-1:0]    samp_q, samp_d;
  logic [GUARD_W-1:0]   guard_q, guard_d;
  logic [15:0]          count_q, count_d;
  logic                 pending_q, pending_d;
  logic                 normal_q, normal_d;
  logic                 abort_eff;
  logic                 req_in;
  logic                 tick_park;

`ifdef TX_PERIODIC_EN
  localparam int PER_W = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 2;
  localparam logic [PER_W-1:0] PER_TICK = PER_W'(PERIOD_CYCLES - 2);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYCLES - 1);
  logic [PER_W-1:0] per_q, per_d;
  logic             per_tick;

  // Free-running period counter; re-aligned at START so the tick lands two cycles ahead of the next START
  always_comb begin
    per_tick = (per_q == PER_TICK);
    if (state_q == S_START) begin
      per_d = PER_W'(1);
    end else if (per_q == PER_LAST) begin
      per_d = '0;
    end else begin
      per_d = per_q + PER_W'(1);
    end
  end

  // Period counter register
  always_ff @(posedge ctx_clk) begin
    if (rtx_rst) begin
      per_q <= '0;
    end else begin
      per_q <= per_d;
    end
  end

  assign req_in    = itx_request | per_tick;
  assign tick_park = per_tick;
`else
  logic unused_period_cfg;
  assign unused_period_cfg = (PERIOD_CYCLES > 0);
  assign req_in    = itx_request;
  assign tick_park = 1'b0;
`endif

  // Next-state and datapath: sequencing, bit/sample timing, pending request and abort handling
  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    tx_en_d   = tx_en_q;
    done_d    = 1'b0;
    bit_d     = bit_q;
    samp_d    = samp_q;
    guard_d   = guard_q;
    count_d   = count_q;
    pending_d = pending_q;
    normal_d  = normal_q;
    abort_eff = iabort && ((state_q == S_LOAD) || (state_q == S_START) || (state_q == S_TRANSMIT));

    case (state_q)
      S_IDLE: begin
        if ((req_in || pending_q) && ienable) state_d = S_LOAD;
      end
      S_LOAD: begin
        pending_d = 1'b0;
        seq_d     = isequence;
        tx_en_d   = 1'b1;
        state_d   = S_START;
      end
      S_START: begin
        bit_d   = '0;
        samp_d  = '0;
        state_d = S_TRANSMIT;
      end
      S_TRANSMIT: begin
        if (samp_q == SAMP_LAST) begin
          samp_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d    = '0;
            tx_en_d  = 1'b0;
            count_d  = count_q + 16'd1;
            normal_d = 1'b1;
            guard_d  = '0;
            state_d  = S_GUARD;
          end else begin
            bit_d = bit_q + IDX_W'(1);
          end
        end else begin
          samp_d = samp_q + SAMP_W'(1);
        end
      end
      S_GUARD: begin
        if (guard_q == GUARD_LAST) begin
          done_d   = normal_q;
          normal_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          guard_d = guard_q + GUARD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A request arriving while busy is remembered once; a parked periodic tick waits out ienable=0
    if ((state_q != S_IDLE) && req_in && !abort_eff) begin
      pending_d = 1'b1;
    end else if ((state_q == S_IDLE) && tick_park && !ienable) begin
      pending_d = 1'b1;
    end

    // Abort overrides everything: straight to guard, modulator off, nothing counted, nothing remembered
    if (abort_eff) begin
      seq_d     = seq_q;
      state_d   = S_GUARD;
      tx_en_d   = 1'b0;
      guard_d   = '0;
      bit_d     = '0;
      samp_d    = '0;
      count_d   = count_q;
      normal_d  = 1'b0;
      pending_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge ctx_clk) begin
    if (rtx_rst) begin
      state_q   <= S_IDLE;
      seq_q     <= '0;
      tx_en_q   <= 1'b0;
      done_q    <= 1'b0;
      bit_q     <= '0;
      samp_q    <= '0;
      guard_q   <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      normal_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      tx_en_q   <= tx_en_d;
      done_q    <= done_d;
      bit_q     <= bit_d;
      samp_q    <= samp_d;
      guard_q   <= guard_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      normal_q  <= normal_d;
    end
  end

  assign obinary_sequence = seq_q;
  assign ostart_interrupt = (state_q == S_START);
  assign otx_enable       = tx_en_q;
  assign obusy            = (state_q != S_IDLE);
  assign odone            = done_q;
  assign obit_index       = bit_q;
  assign otx_count        = count_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// tb/tb_tx_scheduler.sv - directed self-checking bench for tx_scheduler
module tb_tx_scheduler;

  localparam int SB     = 64;
  localparam int SS     = 10;
  localparam int GC     = 20;
  localparam int PC     = 800;
  localparam int TX_LEN = SB * SS;
  localparam int IW     = $clog2(SB);
  localparam logic [SB-1:0] ALT = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [SB-1:0] PAT = 64'h0123_4567_89AB_CDEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          req = 1'b0;
  logic          abort = 1'b0;
  logic [SB-1:0] seq_in = '0;
  logic [SB-1:0] obinary_sequence;
  logic          ostart_interrupt;
  logic          otx_enable;
  logic          obusy;
  logic          odone;
  logic [IW-1:0] obit_index;
  logic [15:0]   otx_count;

  int n_tests = 0;
  int n_fail  = 0;

  tx_scheduler #(
    .SEQ_BITS(SB), .SYMBOL_SAMPLES(SS), .GUARD_CYCLES(GC), .PERIOD_CYCLES(PC)
  ) dut (
    .ctx_clk(clk), .rtx_rst(rst), .ienable(en), .itx_request(req), .iabort(abort),
    .isequence(seq_in), .obinary_sequence(obinary_sequence), .ostart_interrupt(ostart_interrupt),
    .otx_enable(otx_enable), .obusy(obusy), .odone(odone), .obit_index(obit_index),
    .otx_count(otx_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; abort = 1'b0; en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_flags"}, 64'({obusy, ostart_interrupt, otx_enable, odone}), 64'h0);
    check_eq({tag, "_idx"}, 64'(obit_index), 64'h0);
    check_eq({tag, "_cnt"}, 64'(otx_count), 64'h0);
    check_eq({tag, "_seq"}, 64'(obinary_sequence), 64'h0);
  endtask

  // Entered at the negedge of the LOAD cycle; returns at the negedge of the first IDLE cycle
  task automatic observe_tx(input int req_a, input int req_b, input int abort_at, input int chg_at,
                            input logic [SB-1:0] chg_val, output int tx_cyc, output int guard_cyc,
                            output int idx_err, output int last_idx, output int done_seen,
                            output int stray);
    int j;
    tx_cyc = 0; guard_cyc = 0; idx_err = 0; last_idx = -1; done_seen = 0; stray = 0;
    check_eq("load_state", 64'({ostart_interrupt, otx_enable, obusy}), 64'b001);
    req = 1'b0;
    @(negedge clk);
    check_eq("start_state", 64'({ostart_interrupt, otx_enable, obusy}), 64'b111);
    @(negedge clk);
    j = 0;
    while (otx_enable && j < TX_LEN + 10) begin
      if (int'(obit_index) != j / SS) idx_err++;
      if (ostart_interrupt || odone || !obusy) stray++;
      last_idx = int'(obit_index);
      req   = (j == req_a) || (j == req_b);
      abort = (j == abort_at);
      if (j == chg_at) seq_in = chg_val;
      j++;
      @(negedge clk);
    end
    tx_cyc = j;
    req = 1'b0; abort = 1'b0;
    j = 0;
    while (obusy && j < GC + 10) begin
      if (odone || otx_enable || ostart_interrupt) stray++;
      j++;
      @(negedge clk);
    end
    guard_cyc = j;
    done_seen = int'(odone);
  endtask

  task automatic idle_busy_count(input int n, output int busy_cyc);
    busy_cyc = 0;
    repeat (n) begin
      @(negedge clk);
      if (obusy) busy_cyc++;
    end
  endtask

  task automatic reset_mid_tx(input int exp_cnt);
    repeat (30) @(negedge clk);
    check_eq("pre_rst_en", 64'(otx_enable), 64'h1);
    check_eq("pre_rst_cnt", 64'(otx_count), 64'(exp_cnt));
    rst = 1'b1; req = 1'b1; abort = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst = 1'b0; req = 1'b0;
  endtask

  initial begin
    int tx, gd, ie, li, dn, sd, bc, c, n;
    int st[3];

    do_reset();
    check_reset_outputs("reset");

`ifdef TX_PERIODIC_EN
    c = 0; n = 0;
    while (n < 3 && c < 3 * PC + 20) begin
      if (ostart_interrupt) begin
        st[n] = c;
        n++;
      end
      c++;
      @(negedge clk);
    end
    check_eq("per_starts", 64'(n), 64'd3);
    if (n == 3) begin
      check_eq("per_first", 64'(st[0]), 64'(PC));
      check_eq("per_gap1", 64'(st[1] - st[0]), 64'(PC));
      check_eq("per_gap2", 64'(st[2] - st[1]), 64'(PC));
    end
    reset_mid_tx(2);
`else
    // Single transmission with the input sequence changed mid-flight
    seq_in = ALT; req = 1'b1;
    @(negedge clk);
    observe_tx(-1, -1, -1, 50, ~ALT, tx, gd, ie, li, dn, sd);
    check_eq("a_tx_len", 64'(tx), 64'(TX_LEN));
    check_eq("a_guard_len", 64'(gd), 64'(GC));
    check_eq("a_idx_err", 64'(ie), 64'h0);
    check_eq("a_last_idx", 64'(li), 64'(SB - 1));
    check_eq("a_done", 64'(dn), 64'h1);
    check_eq("a_stray", 64'(sd), 64'h0);
    check_eq("a_count", 64'(otx_count), 64'h1);
    check_eq("a_seq_held", 64'(obinary_sequence), 64'(ALT));
    @(negedge clk);
    check_eq("a_done_pulse", 64'({odone, obusy}), 64'b00);

    // Two requests during TRANSMIT yield exactly one extra transmission
    do_reset();
    seq_in = ALT; req = 1'b1;
    @(negedge clk);
    observe_tx(100, 200, -1, -1, '0, tx, gd, ie, li, dn, sd);
    check_eq("b_tx1_len", 64'(tx), 64'(TX_LEN));
    check_eq("b_tx1_done", 64'(dn), 64'h1);
    check_eq("b_tx1_count", 64'(otx_count), 64'h1);
    seq_in = PAT;
    @(negedge clk);
    check_eq("b_load_after_guard", 64'(obusy), 64'h1);
    observe_tx(-1, -1, -1, -1, '0, tx, gd, ie, li, dn, sd);
    check_eq("b_tx2_len", 64'(tx), 64'(TX_LEN));
    check_eq("b_tx2_done", 64'(dn), 64'h1);
    check_eq("b_count", 64'(otx_count), 64'h2);
    check_eq("b_seq_reload", 64'(obinary_sequence), 64'(PAT));
    idle_busy_count(8, bc);
    check_eq("b_no_third", 64'(bc), 64'h0);

    // Abort with a simultaneous request at TRANSMIT cycle 500, after a pending request at 100
    do_reset();
    seq_in = PAT; req = 1'b1;
    @(negedge clk);
    observe_tx(100, 500, 500, -1, '0, tx, gd, ie, li, dn, sd);
    check_eq("c_tx_len", 64'(tx), 64'd501);
    check_eq("c_guard_len", 64'(gd), 64'(GC));
    check_eq("c_last_idx", 64'(li), 64'd50);
    check_eq("c_no_done", 64'(dn), 64'h0);
    check_eq("c_count", 64'(otx_count), 64'h0);
    idle_busy_count(8, bc);
    check_eq("c_pending_cleared", 64'(bc), 64'h0);

    // ienable gates only the start; a transmission underway completes with ienable low
    do_reset();
    seq_in = ALT; en = 1'b0; req = 1'b1;
    idle_busy_count(5, bc);
    check_eq("d_blocked", 64'(bc), 64'h0);
    en = 1'b1;
    @(negedge clk);
    check_eq("d_load_on_enable", 64'(obusy), 64'h1);
    en = 1'b0;
    observe_tx(-1, -1, -1, -1, '0, tx, gd, ie, li, dn, sd);
    check_eq("d_tx_len", 64'(tx), 64'(TX_LEN));
    check_eq("d_done", 64'(dn), 64'h1);
    check_eq("d_count", 64'(otx_count), 64'h1);
    en = 1'b1;

    // Reset in the middle of a transmission
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    reset_mid_tx(1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_scheduler.md
TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 The block SHALL have parameter SEQ_BITS, default 1024: number of bits per transmitted sequence.
REQ-002 The block SHALL have parameter SYMBOL_SAMPLES, default 40: modulator clocks per bit.
REQ-003 The block SHALL have parameter GUARD_CYCLES, default 4096: idle clocks between transmissions, minimum 1.
REQ-004 The block SHALL have parameter PERIOD_CYCLES, default 65536: auto-trigger period, used only when TX_PERIODIC_EN is defined.
REQ-005 The block SHALL have port ctx_clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rtx_rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port ienable, input, 1 bit: while low, new transmissions are not started.
REQ-008 The block SHALL have port itx_request, input, 1 bit: transmit request, sampled every cycle.
REQ-009 The block SHALL have port iabort, input, 1 bit: terminates the current transmission.
REQ-010 The block SHALL have port isequence, input, SEQ_BITS bits: sequence to transmit.
REQ-011 The block SHALL have port obinary_sequence, output, SEQ_BITS bits: registered sequence to the modulator.
REQ-012 The block SHALL have port ostart_interrupt, output, 1 bit: one-cycle start pulse to the modulator.
REQ-013 The block SHALL have port otx_enable, output, 1 bit: modulator enable.
REQ-014 The block SHALL have port obusy, output, 1 bit: high in every state except IDLE.
REQ-015 The block SHALL have port odone, output, 1 bit: one-cycle pulse on normal completion.
REQ-016 The block SHALL have port obit_index, output, clog2(SEQ_BITS) bits: index of the bit currently on air.
REQ-017 The block SHALL have port otx_count, output, 16 bits: count of completed transmissions, wraps 65535->0.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, START, TRANSMIT and GUARD.
REQ-019 IDLE->LOAD: in the cycle after a clock edge at which (itx_request or pending) and ienable=1.
REQ-020 LOAD SHALL last 1 cycle: obinary_sequence<=isequence; otx_enable<=1; pending cleared.
REQ-021 START SHALL last 1 cycle with ostart_interrupt=1; ostart_interrupt SHALL be 0 in all other states.
REQ-022 TRANSMIT SHALL last exactly SEQ_BITS*SYMBOL_SAMPLES cycles (40960 at default parameters), tracked by a sample counter 0..SYMBOL_SAMPLES-1 and by obit_index.
REQ-023 obit_index SHALL be 0 on TRANSMIT entry and increment on each sample-counter wrap; it SHALL hold SEQ_BITS-1 in the final TRANSMIT cycle.
REQ-024 The TRANSMIT exit cycle SHALL perform TRANSMIT->GUARD, otx_enable<=0 and otx_count+1.
REQ-025 GUARD SHALL last GUARD_CYCLES cycles and then go to IDLE; odone=1 in the first IDLE cycle after a normal GUARD only.
REQ-026 obinary_sequence SHALL be stable from LOAD until the next LOAD; isequence changes outside LOAD SHALL be ignored.
REQ-027 itx_request=1 in any non-IDLE state SHALL set a one-deep pending flag; further requests while pending is set SHALL be dropped.
REQ-028 A pending request SHALL be serviced in the first IDLE cycle, with the next LOAD one cycle later.
REQ-029 iabort=1 in LOAD, START or TRANSMIT SHALL cause the next state GUARD, otx_enable=0 and pending cleared, with no odone and no otx_count increment.
REQ-030 iabort in IDLE or GUARD SHALL have no effect.
REQ-031 ienable=0 SHALL block only the IDLE->LOAD transition; a transmission already underway SHALL complete.
REQ-032 When iabort and itx_request are both high, abort SHALL win and the request SHALL NOT set pending.

Reset
REQ-033 With rtx_rst=1 at a clock edge, every state SHALL be forced, from any state, to: FSM=IDLE, obinary_sequence=0, ostart_interrupt=0, otx_enable=0, obusy=0, odone=0, obit_index=0, otx_count=0, pending=0, and all counters=0.
REQ-034 Reset SHALL take priority over all inputs.

Configuration
REQ-035 When macro TX_PERIODIC_EN is defined, an internal counter SHALL generate an internal request every PERIOD_CYCLES clocks, counted from each START cycle and from reset release.
REQ-036 The internal request SHALL be ORed with itx_request, including for the pending rule.
REQ-037 The PERIOD_CYCLES counter SHALL free-run even while ienable=0, with its request held pending.
REQ-038 When TX_PERIODIC_EN is undefined, no period counter SHALL exist and only itx_request SHALL start transmissions.

Verification
REQ-039 The bench SHALL check: reset, then itx_request pulse at cycle 0 -> LOAD at cycle 1, ostart_interrupt at cycle 2, TRANSMIT for 40960 cycles, otx_enable falling at GUARD entry, odone 4096 cycles later, otx_count=1.
REQ-040 The bench SHALL check: isequence=alternating 1010..., changed mid-TRANSMIT -> obinary_sequence holds the LOAD-time value; obit_index reads 0, 1, ..., 1023, advancing every 40 cycles.
REQ-041 The bench SHALL check: a second itx_request at TRANSMIT cycle 100 and a third at cycle 200 -> exactly one extra transmission, starting 1 cycle after GUARD ends; otx_count=2.
REQ-042 The bench SHALL check: iabort at TRANSMIT cycle 500 -> GUARD next cycle, no odone, otx_count unchanged, pending cleared.
REQ-043 The bench SHALL check: ienable=0 with itx_request high in IDLE -> stays IDLE; ienable raised -> LOAD next cycle.
REQ-044 The bench SHALL check: with TX_PERIODIC_EN defined and PERIOD_CYCLES=50000 -> ostart_interrupt pulses exactly 50000 cycles apart; rtx_rst mid-TRANSMIT -> all outputs at reset values on the next cycle.
